// File: rtl/i2c_bus_monitor_pkg.sv
// Shared I2C definitions: monitor FSM encodings, byte width and ACK level.
package i2c_bus_monitor_pkg;

    typedef enum logic [1:0] {
        I2C_MON_IDLE = 2'd0,
        I2C_MON_DATA = 2'd1,
        I2C_MON_ACK  = 2'd2
    } mon_state_t;

    localparam int   I2C_BYTE_W    = 8;
    localparam int   I2C_BIT_CNT_W = $clog2(I2C_BYTE_W);
    localparam logic I2C_ACK       = 1'b0;

endpackage

// File: rtl/i2c_bus_monitor_if.sv
// Filtered bus lines in, decoded bus events out; slave = monitor, master = line source/consumer.
interface i2c_bus_monitor_if;
    import i2c_bus_monitor_pkg::*;

    logic                  i_scl;
    logic                  i_sda;
    logic                  o_busy;
    logic                  o_start;
    logic                  o_stop;
    logic                  o_byte_valid;
    logic [I2C_BYTE_W-1:0] o_byte;
    logic                  o_first;
    logic                  o_ack_valid;
    logic                  o_ack;
    logic                  o_timeout;

    modport slave (
        input  i_scl, i_sda,
        output o_busy, o_start, o_stop, o_byte_valid, o_byte, o_first,
               o_ack_valid, o_ack, o_timeout
    );

    modport master (
        output i_scl, i_sda,
        input  o_busy, o_start, o_stop, o_byte_valid, o_byte, o_first,
               o_ack_valid, o_ack, o_timeout
    );

endinterface

// File: rtl/i2c_bus_monitor_cond_detect.sv
// Bus condition decode: SCL rise, START and STOP from the current and previous line samples.
module i2c_cond_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic scl_rise,
    output logic start_det,
    output logic stop_det
);

    logic scl_q;
    logic sda_q;

    // Previous samples reset to an idle bus so nothing fires out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= i_scl;
            sda_q <= i_sda;
        end
    end

    // START/STOP need SCL high in both samples, so a joint SCL+SDA change is never one.
    assign scl_rise  = i_scl & ~scl_q;
    assign start_det = i_scl & scl_q & sda_q & ~i_sda;
    assign stop_det  = i_scl & scl_q & ~sda_q & i_sda;

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: reports START/STOP, bytes, ACK bits, busy and SCL-low timeout.
//   state | meaning
//   IDLE  | bus free, SCL rises ignored
//   DATA  | shifting 8 data bits of a byte
//   ACK   | waiting for the 9th (ACK/NACK) bit
module i2c_bus_monitor
    import i2c_bus_monitor_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic               i_clk,
    input  logic               i_rst,
    i2c_bus_monitor_if.slave   bus
);

    localparam int TMO_W      = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam int TMO_LAST_I = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0;
    localparam logic [TMO_W-1:0]         TMO_LAST = TMO_W'(TMO_LAST_I);
    localparam logic [I2C_BIT_CNT_W-1:0] BIT_LAST = I2C_BIT_CNT_W'(I2C_BYTE_W - 1);

    mon_state_t               state;
    logic [I2C_BIT_CNT_W-1:0] bit_cnt;
    logic [I2C_BYTE_W-2:0]    shreg;
    logic                     first;
    logic [TMO_W-1:0]         tmo_cnt;

    logic scl_rise;
    logic start_det;
    logic stop_det;
    logic tmo_run;
    logic tmo_hit;

    i2c_cond_detect u_cond (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_scl     (bus.i_scl),
        .i_sda     (bus.i_sda),
        .scl_rise  (scl_rise),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign tmo_run = (TIMEOUT_CLKS != 0) && (state != I2C_MON_IDLE) && !bus.i_scl;
    assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state            <= I2C_MON_IDLE;
            bit_cnt          <= '0;
            shreg            <= '0;
            first            <= 1'b0;
            tmo_cnt          <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_start      <= 1'b0;
            bus.o_stop       <= 1'b0;
            bus.o_byte_valid <= 1'b0;
            bus.o_byte       <= '0;
            bus.o_first      <= 1'b0;
            bus.o_ack_valid  <= 1'b0;
            bus.o_ack        <= 1'b0;
            bus.o_timeout    <= 1'b0;
        end else begin
            bus.o_start      <= 1'b0;
            bus.o_stop       <= 1'b0;
            bus.o_byte_valid <= 1'b0;
            bus.o_ack_valid  <= 1'b0;
            bus.o_timeout    <= 1'b0;

            // START, STOP, timeout and SCL rise are mutually exclusive by decode.
            if (stop_det) begin
                bus.o_stop <= 1'b1;
                bus.o_busy <= 1'b0;
                state      <= I2C_MON_IDLE;
                tmo_cnt    <= '0;
            end else if (start_det) begin
                bus.o_start <= 1'b1;
                bus.o_busy  <= 1'b1;
                state       <= I2C_MON_DATA;
                bit_cnt     <= '0;
                first       <= 1'b1;
                tmo_cnt     <= '0;
            end else if (tmo_hit) begin
                bus.o_timeout <= 1'b1;
                bus.o_busy    <= 1'b0;
                state         <= I2C_MON_IDLE;
                tmo_cnt       <= '0;
            end else begin
                if (scl_rise)
                    tmo_cnt <= '0;
                else if (tmo_run)
                    tmo_cnt <= tmo_cnt + 1'b1;

                case (state)
                    I2C_MON_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[I2C_BYTE_W-3:0], bus.i_sda};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                bus.o_byte       <= {shreg, bus.i_sda};
                                bus.o_first      <= first;
                                bus.o_byte_valid <= 1'b1;
                                state            <= I2C_MON_ACK;
                            end
                        end
                    end
                    I2C_MON_ACK: begin
                        if (scl_rise) begin
                            bus.o_ack       <= (bus.i_sda == I2C_ACK);
                            bus.o_ack_valid <= 1'b1;
                            first           <= 1'b0;
                            bit_cnt         <= '0;
                            state           <= I2C_MON_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: bus transactions driven bit by bit, events counted and logged.
module tb_i2c_bus_monitor;
    import i2c_bus_monitor_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_bus_monitor_if bus();

    i2c_bus_monitor #(.TIMEOUT_CLKS(20)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    int n_start = 0, n_stop = 0, n_byte = 0, n_ack = 0, n_tmo = 0;
    int s_start, s_stop, s_byte, s_ack, s_tmo;
    logic [7:0] byte_log  [16];
    logic       first_log [16];
    logic       ack_log   [16];
    int tmo_at;

    // Event monitor samples just after each active edge.
    always @(posedge clk) begin
        #1;
        if (bus.o_start) n_start++;
        if (bus.o_stop)  n_stop++;
        if (bus.o_timeout) n_tmo++;
        if (bus.o_byte_valid) begin
            byte_log[n_byte & 15]  = bus.o_byte;
            first_log[n_byte & 15] = bus.o_first;
            n_byte++;
        end
        if (bus.o_ack_valid) begin
            ack_log[n_ack & 15] = bus.o_ack;
            n_ack++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_start = n_start; s_stop = n_stop; s_byte = n_byte; s_ack = n_ack; s_tmo = n_tmo;
    endtask

    task automatic start_idle();
        bus.i_sda = 1'b0; tick(2);
        bus.i_scl = 1'b0; tick(2);
    endtask

    task automatic rstart();
        bus.i_sda = 1'b1; tick(1);
        bus.i_scl = 1'b1; tick(2);
        bus.i_sda = 1'b0; tick(2);
        bus.i_scl = 1'b0; tick(2);
    endtask

    task automatic send_bit(input logic b);
        bus.i_sda = b;    tick(2);
        bus.i_scl = 1'b1; tick(2);
        bus.i_scl = 1'b0; tick(1);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic stop();
        bus.i_sda = 1'b0; tick(2);
        bus.i_scl = 1'b1; tick(2);
        bus.i_sda = 1'b1; tick(2);
    endtask

    initial begin
        bus.i_scl = 1'b1;
        bus.i_sda = 1'b1;
        rst = 1'b1;
        tick(2);
        check("rst_busy",  32'(bus.o_busy), 0);
        check("rst_byte",  32'(bus.o_byte), 0);
        check("rst_first", 32'(bus.o_first), 0);
        check("rst_ack",   32'(bus.o_ack), 0);
        rst = 1'b0;

        // Idle bus for 100 cycles: nothing happens.
        tick(100);
        check("idle_events", 32'(n_start + n_stop + n_byte + n_ack + n_tmo), 0);
        check("idle_busy", 32'(bus.o_busy), 0);
        check("idle_byte", 32'(bus.o_byte), 0);

        // Address 0xA4 + ACK, data 0x5A + NACK.
        snap();
        start_idle();
        check("t2_start", 32'(n_start - s_start), 1);
        check("t2_busy_on", 32'(bus.o_busy), 1);
        send_byte(8'hA4); send_bit(1'b0);
        send_byte(8'h5A); send_bit(1'b1);
        stop();
        check("t2_nbytes", 32'(n_byte - s_byte), 2);
        check("t2_byte0",  32'(byte_log[s_byte & 15]), 32'h A4);
        check("t2_first0", 32'(first_log[s_byte & 15]), 1);
        check("t2_ack0",   32'(ack_log[s_ack & 15]), 1);
        check("t2_byte1",  32'(byte_log[(s_byte + 1) & 15]), 32'h5A);
        check("t2_first1", 32'(first_log[(s_byte + 1) & 15]), 0);
        check("t2_ack1",   32'(ack_log[(s_ack + 1) & 15]), 0);
        check("t2_stop",   32'(n_stop - s_stop), 1);
        check("t2_busy_off", 32'(bus.o_busy), 0);

        // Partial byte aborted by repeated START.
        snap();
        start_idle();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rstart();
        send_byte(8'h3C); send_bit(1'b0);
        stop();
        check("t3_starts", 32'(n_start - s_start), 2);
        check("t3_nbytes", 32'(n_byte - s_byte), 1);
        check("t3_byte",   32'(byte_log[s_byte & 15]), 32'h3C);
        check("t3_first",  32'(first_log[s_byte & 15]), 1);

        // Joint SCL/SDA transitions while idle are not conditions.
        snap();
        bus.i_scl = 1'b0; bus.i_sda = 1'b0; tick(2);
        bus.i_scl = 1'b1; bus.i_sda = 1'b1; tick(2);
        check("t4_no_start", 32'(n_start - s_start), 0);
        check("t4_no_stop",  32'(n_stop - s_stop), 0);
        check("t4_idle",     32'(bus.o_busy), 0);
        // First bit: SCL rises together with SDA 0->1, so it samples 1.
        snap();
        start_idle();
        bus.i_scl = 1'b1; bus.i_sda = 1'b1; tick(2);
        bus.i_scl = 1'b0; tick(1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_bit(1'b0);
        stop();
        check("t4_start", 32'(n_start - s_start), 1);
        check("t4_byte",  32'(byte_log[s_byte & 15]), 32'hB5);
        check("t4_first", 32'(first_log[s_byte & 15]), 1);

        // SCL held low after 2 bits: timeout on the 20th low cycle.
        snap();
        start_idle();
        send_bit(1'b1);
        bus.i_sda = 1'b0; tick(2);
        bus.i_scl = 1'b1; tick(2);
        bus.i_scl = 1'b0;
        tmo_at = 0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            if (bus.o_timeout && tmo_at == 0) tmo_at = i;
        end
        tick(1);
        check("t5_tmo_cycle", 32'(tmo_at), 20);
        check("t5_tmo_count", 32'(n_tmo - s_tmo), 1);
        check("t5_busy",      32'(bus.o_busy), 0);
        check("t5_no_byte",   32'(n_byte - s_byte), 0);
        bus.i_sda = 1'b1; tick(1);
        bus.i_scl = 1'b1; tick(2);

        // Reset mid-byte, then a headerless byte must be ignored.
        start_idle();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        rst = 1'b1; tick(2);
        check("t6_rst_busy", 32'(bus.o_busy), 0);
        check("t6_rst_byte", 32'(bus.o_byte), 0);
        check("t6_rst_ack",  32'(bus.o_ack), 0);
        rst = 1'b0; tick(2);
        snap();
        send_byte(8'h55); send_bit(1'b0);
        check("t6_no_bytes", 32'(n_byte - s_byte), 0);
        check("t6_no_acks",  32'(n_ack - s_ack), 0);
        check("t6_no_busy",  32'(bus.o_busy), 0);
        bus.i_sda = 1'b1; tick(1);
        bus.i_scl = 1'b1; tick(2);
        snap();
        start_idle();
        send_byte(8'h81); send_bit(1'b0);
        stop();
        check("t6_nbytes", 32'(n_byte - s_byte), 1);
        check("t6_byte",   32'(byte_log[s_byte & 15]), 32'h81);
        check("t6_first",  32'(first_log[s_byte & 15]), 1);
        check("t6_ack",    32'(ack_log[s_ack & 15]), 1);
        check("t6_stop",   32'(n_stop - s_stop), 1);

        tick(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
